// File: rtl/hack_soc_pkg.sv
// Shared SoC definitions: default bus widths and the VRAM arbiter FSM state encoding.
package hack_soc_pkg;

  localparam int HACK_AW = 16;
  localparam int HACK_DW = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_DISP = 2'd1,
    BUSY_CPU  = 2'd2,
    DONE      = 2'd3
  } arb_state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Two-requester (display, CPU) arbiter in front of a single QSPI SRAM controller port.
// Optional CPU starvation guard is enabled by defining VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter
  import hack_soc_pkg::*;
#(
  parameter int AW             = HACK_AW,
  parameter int DW             = HACK_DW,
  parameter int MAX_DISP_BURST = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_rdata,
  output logic          disp_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  if (MAX_DISP_BURST < 1 || MAX_DISP_BURST > 15) begin : g_bad_burst
    $error("vram_arbiter: MAX_DISP_BURST must be within 1..15");
  end

  arb_state_e r_state;
  logic       w_any_req;
  logic       w_cpu_win;

  assign w_any_req = disp_req | cpu_req;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int            CW      = $clog2(MAX_DISP_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DISP_BURST);

  logic [CW-1:0] r_starve_cnt;

  // Once the display has won MAX_DISP_BURST times in a row over a waiting CPU, the CPU wins.
  assign w_cpu_win = cpu_req & (~disp_req | (r_starve_cnt == MAX_CNT));

  // Starvation counter, updated only when an IDLE decision is taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (!cpu_req || w_cpu_win) begin
        r_starve_cnt <= '0;
      end else begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  assign w_cpu_win = cpu_req & ~disp_req;
`endif

  // Arbitration FSM with registered memory-side and requester-side outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      disp_rdata <= '0;
      disp_ack   <= 1'b0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            mem_req <= 1'b1;
            if (w_cpu_win) begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              r_state   <= BUSY_CPU;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= disp_addr;
              mem_wdata <= '0;
              r_state   <= BUSY_DISP;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY_DISP: begin
          if (mem_ready) begin
            disp_rdata <= mem_rdata;
            disp_ack   <= 1'b1;
            mem_req    <= 1'b0;
            r_state    <= DONE;
          end else begin
            r_state <= BUSY_DISP;
          end
        end
        BUSY_CPU: begin
          // Writes also load cpu_rdata with whatever the controller returns.
          if (mem_ready) begin
            cpu_rdata <= mem_rdata;
            cpu_ack   <= 1'b1;
            mem_req   <= 1'b0;
            r_state   <= DONE;
          end else begin
            r_state <= BUSY_CPU;
          end
        end
        DONE: begin
          disp_ack <= 1'b0;
          cpu_ack  <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          mem_req  <= 1'b0;
          disp_ack <= 1'b0;
          cpu_ack  <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter; expected grant order follows VRAM_ARB_STARVE_GUARD_EN.
module tb_vram_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_rdata;
  logic          disp_ack;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  int check_cnt = 0;
  int pass_cnt = 0;
  int cpu_ack_seen = 0;

  vram_arbiter #(.AW(AW), .DW(DW), .MAX_DISP_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_ack(disp_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cpu_ack) cpu_ack_seen <= cpu_ack_seen + 1;
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if ({mem_req, mem_we, disp_ack, cpu_ack} !== 4'b0000) $display("FAIL reset_ctrl: got %b expected 0000", {mem_req, mem_we, disp_ack, cpu_ack});
    else pass_cnt++;
    check_cnt++;
    if ({mem_addr, mem_wdata, disp_rdata, cpu_rdata} !== 64'h0) $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, disp_rdata, cpu_rdata});
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (mem_req !== 1'b0) $display("FAIL idle_after_release: mem_req got %b expected 0", mem_req);
    else pass_cnt++;
  endtask

  task automatic test_cpu_write();
    int hi;
    int extra;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0123; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    check_cnt++;
    if (mem_req !== 1'b0) $display("FAIL cpu_wr_no_early_grant: mem_req got %b expected 0", mem_req);
    else pass_cnt++;
    @(posedge clk);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) hi++;
      if (i == 0) begin
        check_cnt++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0123, 16'hBEEF})
          $display("FAIL cpu_wr_mem_bus: got we=%b addr=%h wdata=%h expected we=1 addr=0123 wdata=beef", mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
      end
      if (i < 5) @(posedge clk);
    end
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    @(negedge clk);
    check_cnt++;
    if (hi !== 6) $display("FAIL cpu_wr_req_len: got %0d cycles expected 6", hi);
    else pass_cnt++;
    check_cnt++;
    if ({cpu_ack, disp_ack, mem_req} !== 3'b100) $display("FAIL cpu_wr_ack: got ack/dack/req=%b expected 100", {cpu_ack, disp_ack, mem_req});
    else pass_cnt++;
    check_cnt++;
    if (cpu_rdata !== 16'h1234) $display("FAIL cpu_wr_rdata: got %h expected 1234", cpu_rdata);
    else pass_cnt++;
    cpu_req = 1'b0;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ack === 1'b1 || mem_req === 1'b1) extra++;
    end
    check_cnt++;
    if (extra !== 0) $display("FAIL cpu_wr_single_ack: got %0d busy cycles after ack expected 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_disp_read();
    disp_req = 1'b1; disp_addr = 16'h4000;
    @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 16'h4000, 16'h0000})
      $display("FAIL disp_rd_mem_bus: got req=%b we=%b addr=%h wdata=%h expected 1 0 4000 0000", mem_req, mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    mem_ready = 1'b1; mem_rdata = 16'hA5A5;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 16'hFFFF;
    @(negedge clk);
    check_cnt++;
    if ({disp_ack, cpu_ack, disp_rdata, cpu_rdata} !== {1'b1, 1'b0, 16'hA5A5, 16'h1234})
      $display("FAIL disp_rd_ack: got dack=%b cack=%b drdata=%h crdata=%h expected 1 0 a5a5 1234", disp_ack, cpu_ack, disp_rdata, cpu_rdata);
    else pass_cnt++;
    disp_req = 1'b0;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({disp_ack, disp_rdata} !== {1'b0, 16'hA5A5}) $display("FAIL disp_rd_hold: got dack=%b drdata=%h expected 0 a5a5", disp_ack, disp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_stray_ready();
    mem_ready = 1'b1; mem_rdata = 16'h5555;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    @(negedge clk);
    check_cnt++;
    if ({disp_ack, cpu_ack, mem_req, disp_rdata, cpu_rdata} !== {3'b000, 16'hA5A5, 16'h1234})
      $display("FAIL stray_ready: got dack=%b cack=%b req=%b drdata=%h crdata=%h expected 0 0 0 a5a5 1234", disp_ack, cpu_ack, mem_req, disp_rdata, cpu_rdata);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
    @(negedge clk);
    check_cnt++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0042}) $display("FAIL cpu_rd_grant: got req=%b we=%b addr=%h expected 1 0 0042", mem_req, mem_we, mem_addr);
    else pass_cnt++;
    mem_ready = 1'b1; mem_rdata = 16'h0BAD;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    cpu_req = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h0BAD}) $display("FAIL cpu_rd_data: got ack=%b rdata=%h expected 1 0bad", cpu_ack, cpu_rdata);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_arbitration();
    string exp_seq;
    int    exp_acks;
    int    base_acks;
    int    gap;
    int    gap_bad;
    byte   got_c;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    exp_seq = "DDDDCDDDDC"; exp_acks = 2;
`else
    exp_seq = "DDDDDDDDDD"; exp_acks = 0;
`endif
    base_acks = cpu_ack_seen;
    gap_bad = 0;
    disp_addr = 16'h4000; cpu_addr = 16'h0123; cpu_we = 1'b0;
    disp_req = 1'b1; cpu_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (mem_req !== 1'b1 && gap < 20);
      if (mem_req !== 1'b1) begin
        check_cnt++;
        $display("FAIL arb_timeout: grant %0d got no mem_req within 20 cycles expected a grant", g);
        break;
      end
      got_c = (mem_addr === 16'h0123) ? "C" : "D";
      check_cnt++;
      if (got_c !== exp_seq[g]) $display("FAIL arb_grant_%0d: got %c expected %c", g, got_c, exp_seq[g]);
      else pass_cnt++;
      if (g > 0 && gap != 3) gap_bad++;
      mem_ready = 1'b1; mem_rdata = 16'h1000 + 16'(g);
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check_cnt++;
    if (gap_bad !== 0) $display("FAIL arb_regrant_gap: got %0d grants not 3 cycles after ready expected 0", gap_bad);
    else pass_cnt++;
    check_cnt++;
    if (cpu_ack_seen - base_acks !== exp_acks) $display("FAIL arb_cpu_acks: got %0d expected %0d", cpu_ack_seen - base_acks, exp_acks);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0777; cpu_wdata = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if (mem_req !== 1'b1) $display("FAIL rst_busy_entry: mem_req got %b expected 1", mem_req);
    else pass_cnt++;
    reset_n = 1'b0;
    #1;
    check_cnt++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, disp_rdata, cpu_rdata, disp_ack, cpu_ack} !== 68'h0)
      $display("FAIL rst_async_clear: got %h expected 0", {mem_req, mem_we, mem_addr, mem_wdata, disp_rdata, cpu_rdata, disp_ack, cpu_ack});
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_cnt++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0777, 16'h1111})
      $display("FAIL rst_regrant: got req=%b we=%b addr=%h wdata=%h expected 1 1 0777 1111", mem_req, mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    mem_ready = 1'b1; mem_rdata = 16'h2222;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    cpu_req = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h2222}) $display("FAIL rst_regrant_ack: got ack=%b rdata=%h expected 1 2222", cpu_ack, cpu_rdata);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_disp_read();
    test_stray_ready();
    test_back_to_back();
    test_arbitration();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter AW, default 16: address width for requesters and memory port.
REQ-002 Parameter DW, default 16: data word width.
REQ-003 Parameter MAX_DISP_BURST, default 4: consecutive display grants allowed while the CPU waits; legal range 1..15.
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port reset_n, input, 1: reset, asynchronous assertion, active-low.
REQ-006 Port disp_req, input, 1: display read request; held high until disp_ack.
REQ-007 Port disp_addr, input, AW: display read address; stable while disp_req is high.
REQ-008 Port disp_rdata, output, DW: display read data; valid when disp_ack=1.
REQ-009 Port disp_ack, output, 1: one-cycle display completion pulse.
REQ-010 Port cpu_req, input, 1: CPU request; held high until cpu_ack.
REQ-011 Port cpu_we, input, 1: 1 selects write, 0 selects read.
REQ-012 Port cpu_addr, input, AW: CPU address.
REQ-013 Port cpu_wdata, input, DW: CPU write data.
REQ-014 Port cpu_rdata, output, DW: CPU read data; valid when cpu_ack=1.
REQ-015 Port cpu_ack, output, 1: one-cycle CPU completion pulse.
REQ-016 Port mem_req, output, 1: request to the QSPI SRAM controller; level signal.
REQ-017 Port mem_we, output, 1: write select to the controller.
REQ-018 Port mem_addr, output, AW: address to the controller.
REQ-019 Port mem_wdata, output, DW: write data to the controller.
REQ-020 Port mem_rdata, input, DW: read data from the controller; valid with mem_ready.
REQ-021 Port mem_ready, input, 1: one-cycle controller completion pulse.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY_DISP, BUSY_CPU and DONE.
REQ-023 In IDLE with any request, the arbiter SHALL register the winner's addr/we/wdata into mem_* and enter BUSY_<winner> on the next edge.
REQ-024 mem_req SHALL be 1 exactly while in BUSY_DISP or BUSY_CPU.
REQ-025 For a display grant, mem_we SHALL be 0 and mem_wdata SHALL be 0.
REQ-026 In BUSY_x on mem_ready=1, the arbiter SHALL capture mem_rdata into x_rdata, pulse x_ack for the next cycle only, and enter DONE.
REQ-027 DONE SHALL last exactly one cycle and then go to IDLE, so a requester dropping req after ack is never regranted; mem_req is 0 in DONE.
REQ-028 Minimum transaction timing: grant at edge t+1, mem_req high from t+1, ack at r+1 when mem_ready is at r, next grant no earlier than r+3.
REQ-029 x_rdata SHALL hold its value until the next capture; a CPU write SHALL load cpu_rdata with mem_rdata as received.
REQ-030 mem_ready in IDLE or DONE SHALL be ignored.
REQ-031 Simultaneous disp_req and cpu_req in IDLE SHALL grant display, except as modified by REQ-035.
REQ-032 A requester dropping req mid-transaction SHALL NOT abort the transaction; the ack still pulses.
REQ-033 A request arriving during BUSY or DONE SHALL wait and be evaluated in the next IDLE.

Reset
REQ-034 While reset_n=0, the arbiter SHALL be in IDLE with every output 0 (mem_*, *_rdata, *_ack) and the starvation counter at 0, including when reset arrives mid-transaction; release is synchronous to clk.

Configuration
REQ-035 With VRAM_ARB_STARVE_GUARD_EN defined:
- a counter of width clog2(MAX_DISP_BURST+1) increments on each display grant made while cpu_req=1;
- it clears on a CPU grant or when cpu_req=0 at an IDLE decision;
- when it equals MAX_DISP_BURST, the CPU SHALL win the next IDLE decision.
REQ-036 Without VRAM_ARB_STARVE_GUARD_EN, the counter SHALL be absent and arbitration SHALL be pure fixed priority to display.

Structure
REQ-037 The FSM state enum and HACK_AW/HACK_DW constants SHALL live in the shared hack_soc_pkg.
REQ-038 No sub-module; the FSM, capture registers and counter are inline.

Verification
REQ-039 cpu_req only, we=1, addr=0x0123, wdata=0xBEEF; mem_ready 5 cycles after grant -> mem_req high 1 cycle after req for 6 cycles, mem_addr=0x0123, mem_we=1, cpu_ack pulses once.
REQ-040 disp_req only, addr=0x4000; mem_rdata=0xA5A5 with mem_ready -> disp_rdata=0xA5A5 and disp_ack=1 in the next cycle; disp_rdata held afterwards.
REQ-041 Both req continuously high, guard enabled, MAX_DISP_BURST=4 -> grant order D,D,D,D,C,D,D,D,D,C.
REQ-042 Same as REQ-041 without the macro -> only display grants; cpu_ack never asserts.
REQ-043 reset_n pulsed low during BUSY_CPU -> all outputs 0 immediately; after release, a pending cpu_req is regranted from IDLE.
REQ-044 Stray mem_ready in IDLE with no requests -> no ack and no state change.
